// File: rtl/col_sched.sv
// Column scheduler: latches an angular position and mode, then streams the selected column
// indices over valid/ready while holding a registered enable mask. Option: COL_SCHED_DROP_COUNT_EN.
module col_sched #(
  parameter int unsigned ROTATIONAL_RES = 1024,
  parameter int unsigned NUM_COLS       = 64,
  parameter int unsigned WINDOW         = 4
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic [$clog2(ROTATIONAL_RES)-1:0] dtheta_in,
  input  logic [1:0]                        mode_in,
  input  logic                              dtheta_valid_in,
  output logic [NUM_COLS-1:0]               col_indices_out,
  output logic [$clog2(NUM_COLS)-1:0]       col_idx_out,
  output logic                              col_valid_out,
  input  logic                              col_ready_in,
  output logic                              col_last_out,
  output logic                              sweep_done_out,
  output logic                              drop_out,
  output logic [15:0]                       drop_count_out
);

  localparam int unsigned DW = $clog2(ROTATIONAL_RES);
  localparam int unsigned CW = $clog2(NUM_COLS);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [CW-1:0]       rem_q, rem_d;   // beats left after the current one
  logic [NUM_COLS-1:0] mask_q, mask_d;
  logic                pend_v_q, pend_v_d;
  logic [DW-1:0]       pend_dt_q, pend_dt_d;
  logic [1:0]          pend_md_q, pend_md_d;
  logic                done_q, done_d;
  logic                drop_q, drop_d;

  logic                hs, fin, use_pend, load;
  logic [DW-1:0]       ld_dt;
  logic [1:0]          ld_md;
  logic [CW-1:0]       ld_center, ld_start, ld_rem;
  logic [NUM_COLS-1:0] ld_mask;

  assign hs  = (state_q == StSweep) && col_ready_in;
  assign fin = hs && (rem_q == '0);
  // A fresh strobe on the final beat supersedes whatever sits in the pending slot.
  assign use_pend = (state_q == StSweep) && fin && !dtheta_valid_in && pend_v_q;
  assign ld_dt    = use_pend ? pend_dt_q : dtheta_in;
  assign ld_md    = use_pend ? pend_md_q : mode_in;

  always_comb begin
    ld_center = CW'(ld_dt >> (DW - CW));
    case (ld_md)
      2'd1: begin
        ld_start = ld_center - CW'(WINDOW);
        ld_rem   = CW'(2 * WINDOW);
      end
      2'd2: begin
        ld_start = ld_center;
        ld_rem   = '0;
      end
      default: begin
        ld_start = '0;
        ld_rem   = CW'(NUM_COLS - 1);
      end
    endcase
    // A column is enabled when its modular offset from the start lies within the span.
    for (int k = 0; k < NUM_COLS; k++) begin
      ld_mask[k] = (CW'(k) - ld_start) <= ld_rem;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    rem_d     = rem_q;
    mask_d    = mask_q;
    pend_v_d  = pend_v_q;
    pend_dt_d = pend_dt_q;
    pend_md_d = pend_md_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    load      = 1'b0;
    if (state_q == StIdle) begin
      load = dtheta_valid_in;
    end else if (fin) begin
      if (dtheta_valid_in) begin
        load     = 1'b1;
        drop_d   = pend_v_q;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        load     = 1'b1;
        pend_v_d = 1'b0;
      end else begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end else begin
      if (hs) begin
        col_d = col_q + 1'b1;
        rem_d = rem_q - 1'b1;
      end
      if (dtheta_valid_in) begin
        pend_v_d  = 1'b1;
        pend_dt_d = dtheta_in;
        pend_md_d = mode_in;
        drop_d    = pend_v_q;
      end
    end
    if (load) begin
      state_d = StSweep;
      col_d   = ld_start;
      rem_d   = ld_rem;
      mask_d  = ld_mask;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StIdle;
      col_q     <= '0;
      rem_q     <= '0;
      mask_q    <= '0;
      pend_v_q  <= 1'b0;
      pend_dt_q <= '0;
      pend_md_q <= '0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      rem_q     <= rem_d;
      mask_q    <= mask_d;
      pend_v_q  <= pend_v_d;
      pend_dt_q <= pend_dt_d;
      pend_md_q <= pend_md_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

`ifdef COL_SCHED_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      drop_cnt_q <= '0;
    end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign drop_count_out = drop_cnt_q;
`else
  assign drop_count_out = '0;
`endif

  assign col_valid_out   = (state_q == StSweep);
  assign col_idx_out     = col_q;
  assign col_last_out    = (state_q == StSweep) && (rem_q == '0);
  assign col_indices_out = mask_q;
  assign sweep_done_out  = done_q;
  assign drop_out        = drop_q;

endmodule

// File: tb/tb_col_sched.sv
// Scoreboard bench for col_sched: requests expand into expected beats in a queue; a negedge
// monitor compares every presented beat, the mask, and the done/drop pulses.
module tb_col_sched;
  localparam int RR = 1024;
  localparam int NC = 64;
  localparam int W  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  dtheta = '0;
  logic [1:0]  mode = '0;
  logic        strobe = 1'b0;
  logic        ready = 1'b0;
  logic [63:0] col_indices;
  logic [5:0]  col_idx;
  logic        col_valid, col_last, sweep_done, drop;
  logic [15:0] drop_count;

  col_sched #(.ROTATIONAL_RES(RR), .NUM_COLS(NC), .WINDOW(W)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .dtheta_in(dtheta), .mode_in(mode),
    .dtheta_valid_in(strobe), .col_indices_out(col_indices), .col_idx_out(col_idx),
    .col_valid_out(col_valid), .col_ready_in(ready), .col_last_out(col_last),
    .sweep_done_out(sweep_done), .drop_out(drop), .drop_count_out(drop_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {int col; bit last;} beat_t;
  beat_t       exp_q[$];
  logic [63:0] exp_mask = '0;
  bit          pend_v = 0;
  int          pend_dt, pend_md;
  bit          exp_drop = 0, exp_done = 0;
  int          exp_cnt = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Reference: a request becomes a list of columns by plain modular arithmetic.
  task automatic expand(int dt, int md);
    int center, start, span;
    center = dt / (RR / NC);
    if (md == 1) begin start = (center - W + NC) % NC; span = 2 * W + 1; end
    else if (md == 2) begin start = center; span = 1; end
    else begin start = 0; span = NC; end
    exp_mask = '0;
    for (int k = 0; k < span; k++) begin
      beat_t b;
      b.col = (start + k) % NC;
      b.last = (k == span - 1);
      exp_mask[b.col] = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  task automatic note_drop(bit d);
    exp_drop = d;
    if (d) begin
`ifdef COL_SCHED_DROP_COUNT_EN
      if (exp_cnt < 65535) exp_cnt++;
`endif
    end
  endtask

  // Monitor + model step: compare state after the last edge, then advance for the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_v = 0; exp_mask = '0; exp_drop = 0; exp_done = 0; exp_cnt = 0;
    end else begin
      bit active, fin;
      active = exp_q.size() != 0;
      check("col_valid", col_valid, active);
      if (active && col_valid) begin
        check("col_idx", col_idx, exp_q[0].col);
        check("col_last", col_last, exp_q[0].last);
      end
      check("mask", col_indices, exp_mask);
      check("sweep_done", sweep_done, exp_done);
      check("drop", drop, exp_drop);
      check("drop_count", drop_count, exp_cnt);
      exp_done = 0;
      note_drop(0);
      if (!active) begin
        if (strobe) expand(dtheta, mode);
      end else begin
        fin = ready && exp_q.size() == 1;
        if (ready) void'(exp_q.pop_front());
        if (fin) begin
          if (strobe) begin note_drop(pend_v); pend_v = 0; expand(dtheta, mode); end
          else if (pend_v) begin pend_v = 0; expand(pend_dt, pend_md); end
          else exp_done = 1;
        end else if (strobe) begin
          note_drop(pend_v);
          pend_v = 1; pend_dt = dtheta; pend_md = mode;
        end
      end
    end
  end

  task automatic cyc(bit s, int dt, int md, bit r);
    @(posedge clk);
    #1;
    strobe = s; dtheta = 10'(dt); mode = 2'(md); ready = r;
  endtask

  task automatic wait_idle();
    int budget = 2000;
    while ((exp_q.size() != 0 || pend_v || col_valid) && budget > 0) begin
      cyc(0, $urandom, $urandom, 1);
      budget--;
    end
    if (budget == 0) check("idle_timeout", 64'd0, 64'd1);
    cyc(0, $urandom, $urandom, 1);
    cyc(0, $urandom, $urandom, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc(0, $urandom, $urandom, 1);
    check("reset_col_idx", col_idx, 0);
    check("reset_col_last", col_last, 0);
    check("reset_valid", col_valid, 0);

    cyc(1, 100, 0, 1); wait_idle();
    cyc(1, 16, 1, 1);  wait_idle();
    cyc(1, 1023, 2, 1); wait_idle();

    // Stalled ALL sweep with two queued requests: the second overwrites the first.
    cyc(1, 100, 0, 1);
    cyc(0, 7, 3, 0);
    cyc(1, 32, 1, 0);
    cyc(1, 48, 2, 0);
    repeat (7) cyc(0, $urandom, $urandom, 0);
    wait_idle();
`ifdef COL_SCHED_DROP_COUNT_EN
    check("drop_count_after_stall", drop_count, 1);
`else
    check("drop_count_after_stall", drop_count, 0);
`endif

    // Strobe coincides with the final handshake of a single-beat sweep.
    cyc(1, 500, 2, 1);
    cyc(1, 0, 0, 1);
    wait_idle();

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 8) == 0, $urandom, $urandom, ($urandom % 4) != 0);
    end
    wait_idle();

    // Asynchronous reset mid-sweep, away from any clock edge.
    cyc(1, 100, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", col_valid, 0);
    check("async_reset_mask", col_indices, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc(0, $urandom, $urandom, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/col_sched.md
# col_sched

Parametrised column scheduler feeding frame_manager. It latches a rotational position `dtheta` and a selection mode, then produces a registered column-enable mask. It also streams the selected column indices one per handshake, so frame_manager can fetch voxel data column by column. It supports all-column, angular-window and single-column selection, with a one-deep pending slot for positions that arrive mid-sweep.

## Interface
- `ROTATIONAL_RES`, 1024: angular steps per revolution; power of 2.
- `NUM_COLS`, 64: column count; power of 2; must satisfy `NUM_COLS <= ROTATIONAL_RES`.
- `WINDOW`, 4: half-width of window mode; must satisfy `2*WINDOW+1 <= NUM_COLS`.

Ports:
- `clk_in`  in  1  system clock; one clock domain.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `dtheta_in`  in  $clog2(ROTATIONAL_RES)  angular position.
- `mode_in`  in  2  selection mode: 0 ALL, 1 WINDOW, 2 SINGLE, 3 reserved (behaves as ALL).
- `dtheta_valid_in`  in  1  one-cycle request strobe.
- `col_indices_out`  out  NUM_COLS  enable mask of the active sweep.
- `col_idx_out`  out  $clog2(NUM_COLS)  current column index.
- `col_valid_out`  out  1  `col_idx_out` is valid.
- `col_ready_in`  in  1  consumer accepts the current column.
- `col_last_out`  out  1  current beat is the last beat of the sweep.
- `sweep_done_out`  out  1  one-cycle pulse after the last handshake when no request is pending.
- `drop_out`  out  1  one-cycle pulse when a pending request is overwritten.
- `drop_count_out`  out  16  saturating count of dropped requests (see Configuration).

## Operation
- Column arithmetic:
  - center = `dtheta_in >> ($clog2(ROTATIONAL_RES) - $clog2(NUM_COLS))`.
  - All column arithmetic is modulo NUM_COLS, i.e. it wraps by truncation to $clog2(NUM_COLS) bits.
- Start column and span per mode:
  - ALL: start 0, span NUM_COLS.
  - WINDOW: start = center - WINDOW, span 2*WINDOW+1.
  - SINGLE: start = center, span 1.
- Beat k (k = 0 .. span-1) emits column (start + k) mod NUM_COLS. Every emitted column is set in the mask.
- The mask has exactly the emitted columns set. It is held constant for the whole sweep.
- States:
  - IDLE: a strobe latches dtheta and mode, then go to SWEEP.
  - SWEEP: beat counter advances on `col_valid_out && col_ready_in`. The handshake on beat span-1 ends the sweep.
    - If a request is pending, load it and stay in SWEEP.
    - Otherwise go to IDLE.
- A strobe during SWEEP writes the pending slot. If the slot is already full, it is overwritten with the newest request and `drop_out` pulses.
- A strobe in the same cycle as the final handshake behaves as a pending request and is consumed immediately. No drop occurs unless the slot was already full.
- `dtheta_in` and `mode_in` are sampled only on strobe cycles. Changes at other times have no effect.

## Timing
- Reset value of all outputs is 0. On reset the state is IDLE, the pending slot is empty and the counters are cleared.
- Reset acts immediately, including mid-sweep.
- From a strobe in IDLE at cycle N: `col_indices_out`, `col_valid_out=1` and beat 0 are visible at N+1. Latency is 1 cycle.
- One beat per cycle under continuous ready.
- Valid/ready rules:
  - `col_valid_out` is never withdrawn before a handshake.
  - `col_idx_out` and `col_last_out` are stable while valid is high and ready is low.
- Back-to-back sweeps: after the final handshake at cycle M with a pending request, beat 0 of the next sweep appears at M+1. There is no bubble, and the mask updates at M+1.
- Ending without a pending request:
  - `col_valid_out` falls at M+1.
  - `sweep_done_out` pulses at M+1.
  - `col_indices_out` holds the last mask until the next load.
- `drop_out` pulses in the cycle after the overwriting strobe.

## Configuration
- `COL_SCHED_DROP_COUNT_EN` defined: `drop_count_out` increments on each drop and saturates at 16'hFFFF. It is cleared only by reset.
- Macro undefined: the counter logic is removed and `drop_count_out` is tied to 0. `drop_out` is unaffected.

## Test plan
Parameters: ROTATIONAL_RES=1024, NUM_COLS=64, WINDOW=2.
- Reset held, then released, with no strobe -> all outputs 0. Assert `rst_n_in` low mid-sweep -> `col_valid_out` goes to 0 with no clock edge.
- ALL, dtheta=100, ready=1 -> mask all ones; beats 0..63 on consecutive cycles; last on 63; done one cycle after.
- WINDOW, dtheta=16 (center 1) -> beats 63, 0, 1, 2, 3; mask bits {0,1,2,3,63}; last on 3.
- SINGLE, dtheta=1023 -> one beat col 63 with `col_last_out=1`; mask = 1<<63.
- ALL sweep with ready low for 10 cycles, and strobes dtheta=32 (WINDOW), then dtheta=48 (SINGLE) -> one drop pulse. With the macro, `drop_count_out=1`; without it, 0. The next sweep is a single beat col 3 with no bubble, and `col_idx_out` stays stable while ready is low.
- SINGLE sweep with a strobe (dtheta=0, ALL) coinciding with the final handshake -> no drop; beat col 0 at the next cycle; no done pulse.
